// File: rtl/axi_bresp_pkg.sv
// rtl/axi_bresp_pkg.sv - shared B-channel response codes, FSM states and width helper
package axi_bresp_pkg;

    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_EXOKAY = 2'b01;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;
    localparam logic [1:0] BRESP_DECERR = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } bresp_state_t;

    // Index width for n sources; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin requester search with a registered priority pointer
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant_onehot,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] rr_ptr_d;

    // Search from rr_ptr upward with wrap; walking the offsets downward lets the closest hit win.
    always_comb begin
        int j;
        j            = 0;
        grant_onehot = '0;
        grant_idx    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(rr_ptr_q) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (req[IDX_W'(j)]) begin
                grant_onehot              = '0;
                grant_onehot[IDX_W'(j)]   = 1'b1;
                grant_idx                 = IDX_W'(j);
            end
        end
    end

    // Pointer moves just past the winner whenever a grant is actually taken.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (advance && (|req)) begin
            rr_ptr_d = (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/axi_bresp_arbiter.sv
// rtl/axi_bresp_arbiter.sv - merges N upstream B channels into one registered downstream B slot
module axi_bresp_arbiter
    import axi_bresp_pkg::*;
#(
    parameter int N_SRC   = 4,
    parameter int ID_W    = 4,
    parameter int MAXWAIT = 5,
    parameter int CNT_W   = 8,
    localparam int IDX_W  = idx_width(N_SRC)
) (
    input  logic                    AXI_ACLK,
    input  logic                    AXI_ARESET,
    input  logic [N_SRC-1:0]        S_BVALID,
    output logic [N_SRC-1:0]        S_BREADY,
    input  logic [2*N_SRC-1:0]      S_BRESP,
    input  logic [ID_W*N_SRC-1:0]   S_BID,
    output logic                    M_BVALID,
    input  logic                    M_BREADY,
    output logic [1:0]              M_BRESP,
    output logic [IDX_W+ID_W-1:0]   M_BID,
    output logic                    stall_err,
    output logic [CNT_W-1:0]        err_cnt
);

    localparam int WAIT_W = $clog2(MAXWAIT + 1);

    bresp_state_t            state_q, state_d;
    logic [1:0]              bresp_q, bresp_d;
    logic [IDX_W+ID_W-1:0]   bid_q, bid_d;
    logic [WAIT_W-1:0]       wait_q, wait_d;
    logic                    stall_q, stall_d;
    logic [CNT_W-1:0]        err_q, err_d;

    logic                    send;
    logic                    load;
    logic                    any_req;
    logic [N_SRC-1:0]        grant_onehot;
    logic [IDX_W-1:0]        grant_idx;
    logic [1:0]              g_bresp;
    logic [ID_W-1:0]         g_bid;

    rr_arbiter #(
        .N     (N_SRC),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk          (AXI_ACLK),
        .rst          (AXI_ARESET),
        .req          (S_BVALID),
        .advance      (load),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx)
    );

    // Slot is free to take a new response when empty or being drained this cycle; never in reset.
    always_comb begin
        send     = (state_q == SEND);
        load     = !AXI_ARESET && (!send || M_BREADY);
        any_req  = |S_BVALID;
        S_BREADY = (load && any_req) ? grant_onehot : '0;
    end

    // One-hot OR-mux of the granted source's payload.
    always_comb begin
        g_bresp = '0;
        g_bid   = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant_onehot[i]) begin
                g_bresp = g_bresp | S_BRESP[2*i +: 2];
                g_bid   = g_bid   | S_BID[ID_W*i +: ID_W];
            end
        end
    end

    // Slot, FSM, wait watchdog and error counter next-state.
    always_comb begin
        state_d = state_q;
        bresp_d = bresp_q;
        bid_d   = bid_q;
        wait_d  = wait_q;
        stall_d = 1'b0;
        err_d   = err_q;
        if (send && M_BREADY && bresp_q[1] && (err_q != '1)) begin
            err_d = err_q + CNT_W'(1);
        end
        if (load) begin
            wait_d = '0;
            if (any_req) begin
                state_d = SEND;
                bresp_d = g_bresp;
                bid_d   = {grant_idx, g_bid};
            end else begin
                state_d = IDLE;
            end
        end else if (send && (wait_q != WAIT_W'(MAXWAIT))) begin
            wait_d  = wait_q + WAIT_W'(1);
            stall_d = (wait_q == WAIT_W'(MAXWAIT - 1));
        end
    end

    // All state and registered outputs.
    always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
        if (AXI_ARESET) begin
            state_q <= IDLE;
            bresp_q <= '0;
            bid_q   <= '0;
            wait_q  <= '0;
            stall_q <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            bresp_q <= bresp_d;
            bid_q   <= bid_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    assign M_BVALID  = (state_q == SEND);
    assign M_BRESP   = bresp_q;
    assign M_BID     = bid_q;
    assign stall_err = stall_q;
    assign err_cnt   = err_q;

endmodule

// File: tb/tb_axi_bresp_arbiter.sv
// tb/tb_axi_bresp_arbiter.sv - directed vector bench for axi_bresp_arbiter
module tb_axi_bresp_arbiter;
    import axi_bresp_pkg::*;

    logic        clk;
    logic        rst;
    logic [3:0]  s_bvalid;
    logic [3:0]  s_bready;
    logic [7:0]  s_bresp;
    logic [15:0] s_bid;
    logic        m_bvalid;
    logic        m_bready;
    logic [1:0]  m_bresp;
    logic [5:0]  m_bid;
    logic        stall_err;
    logic [7:0]  err_cnt;

    logic [3:0]  s_bready2;
    logic        m_bvalid2;
    logic [1:0]  m_bresp2;
    logic [5:0]  m_bid2;
    logic        stall_err2;
    logic [1:0]  err_cnt2;

    int errors = 0;
    int checks = 0;
    int proto_viol = 0;
    int stall_pulses;

    axi_bresp_arbiter #(.N_SRC(4), .ID_W(4), .MAXWAIT(5), .CNT_W(8)) dut (
        .AXI_ACLK(clk), .AXI_ARESET(rst), .S_BVALID(s_bvalid), .S_BREADY(s_bready),
        .S_BRESP(s_bresp), .S_BID(s_bid), .M_BVALID(m_bvalid), .M_BREADY(m_bready),
        .M_BRESP(m_bresp), .M_BID(m_bid), .stall_err(stall_err), .err_cnt(err_cnt)
    );

    axi_bresp_arbiter #(.N_SRC(4), .ID_W(4), .MAXWAIT(5), .CNT_W(2)) dut2 (
        .AXI_ACLK(clk), .AXI_ARESET(rst), .S_BVALID(s_bvalid), .S_BREADY(s_bready2),
        .S_BRESP(s_bresp), .S_BID(s_bid), .M_BVALID(m_bvalid2), .M_BREADY(m_bready),
        .M_BRESP(m_bresp2), .M_BID(m_bid2), .stall_err(stall_err2), .err_cnt(err_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream B protocol watch: a valid, unaccepted response must stay put.
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic [5:0] pb = '0;
    logic [1:0] ps = '0;
    always @(negedge clk) begin
        if (rst) begin
            pv = 1'b0;
        end else begin
            if (pv && !pr && (!m_bvalid || m_bid != pb || m_bresp != ps)) begin
                proto_viol++;
            end
            pv = m_bvalid;
            pr = m_bready;
            pb = m_bid;
            ps = m_bresp;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]  vld;
        logic [15:0] bid;
        logic [7:0]  resp;
        logic        mrdy;
        logic [3:0]  e_srdy;
        logic        e_mv;
        logic        chk_pay;
        logic [5:0]  e_bid;
        logic [1:0]  e_resp;
        logic [7:0]  e_err;
    } vec_t;

    vec_t vt[8];

    initial begin
        vt[0] = '{4'b0000, 16'h0000, 8'h00, 1'b1, 4'b0000, 1'b0, 1'b1, 6'h00, 2'd0, 8'd0};
        vt[1] = '{4'b0100, 16'h0300, 8'h00, 1'b1, 4'b0100, 1'b0, 1'b1, 6'h00, 2'd0, 8'd0};
        vt[2] = '{4'b0000, 16'h0000, 8'h00, 1'b1, 4'b0000, 1'b1, 1'b1, 6'h23, 2'd0, 8'd0};
        vt[3] = '{4'b0000, 16'h0000, 8'h00, 1'b1, 4'b0000, 1'b0, 1'b0, 6'h00, 2'd0, 8'd0};
        vt[4] = '{4'b1001, 16'h7005, 8'h02, 1'b1, 4'b1000, 1'b0, 1'b0, 6'h00, 2'd0, 8'd0};
        vt[5] = '{4'b0001, 16'h0005, 8'h02, 1'b1, 4'b0001, 1'b1, 1'b1, 6'h37, 2'd0, 8'd0};
        vt[6] = '{4'b0000, 16'h0000, 8'h00, 1'b1, 4'b0000, 1'b1, 1'b1, 6'h05, 2'd2, 8'd0};
        vt[7] = '{4'b0000, 16'h0000, 8'h00, 1'b1, 4'b0000, 1'b0, 1'b0, 6'h00, 2'd0, 8'd1};

        rst = 1'b1; s_bvalid = '0; s_bresp = '0; s_bid = '0; m_bready = 1'b0;
        step(); step();
        rst = 1'b0;

        // Single source, idle gap and pointer wrap from 3 to 0.
        for (int i = 0; i < 8; i++) begin
            s_bvalid = vt[i].vld; s_bid = vt[i].bid; s_bresp = vt[i].resp; m_bready = vt[i].mrdy;
            #1;
            chk($sformatf("v%0d s_bready", i), s_bready, vt[i].e_srdy);
            chk($sformatf("v%0d m_bvalid", i), m_bvalid, vt[i].e_mv);
            chk($sformatf("v%0d err_cnt", i), err_cnt, vt[i].e_err);
            chk($sformatf("v%0d stall", i), stall_err, 0);
            if (vt[i].chk_pay) begin
                chk($sformatf("v%0d m_bid", i), m_bid, vt[i].e_bid);
                chk($sformatf("v%0d m_bresp", i), m_bresp, vt[i].e_resp);
            end
            step();
        end

        // Error counting, with a 2-bit saturating twin.
        rst = 1'b1; #1; rst = 1'b0;
        m_bready = 1'b1;
        begin
            logic [1:0] seq [6];
            seq[0] = BRESP_SLVERR; seq[1] = BRESP_SLVERR; seq[2] = BRESP_SLVERR;
            seq[3] = BRESP_DECERR; seq[4] = BRESP_OKAY;   seq[5] = BRESP_EXOKAY;
            for (int k = 0; k < 6; k++) begin
                s_bvalid = 4'b0001; s_bid = 16'(k); s_bresp = {6'b0, seq[k]};
                #1;
                chk($sformatf("err s_bready %0d", k), s_bready, 4'b0001);
                step();
            end
        end
        s_bvalid = '0;
        step(); step();
        chk("err_cnt after 4 errors", err_cnt, 4);
        chk("err_cnt2 saturate at 4", err_cnt2, 3);
        s_bvalid = 4'b0001; s_bresp = {6'b0, BRESP_SLVERR};
        step();
        s_bvalid = '0;
        step(); step();
        chk("err_cnt after 5 errors", err_cnt, 5);
        chk("err_cnt2 saturate at 5", err_cnt2, 3);

        // Reset in the middle of a held response.
        s_bvalid = 4'b0001; s_bresp = '0; m_bready = 1'b0;
        step();
        chk("pre-reset m_bvalid", m_bvalid, 1);
        #2 rst = 1'b1;
        #1;
        chk("reset m_bvalid", m_bvalid, 0);
        chk("reset s_bready", s_bready, 0);
        chk("reset err_cnt", err_cnt, 0);
        chk("reset err_cnt2", err_cnt2, 0);
        chk("reset stall", stall_err, 0);
        chk("reset m_bid", m_bid, 0);
        chk("reset m_bresp", m_bresp, 0);
        step();
        rst = 1'b0;

        // Fairness: rr_ptr restarts at 0, one grant per cycle, no bubbles.
        s_bvalid = 4'b1111; s_bid = 16'h3210; s_bresp = '0; m_bready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("fair s_bready %0d", k), s_bready, 32'(1) << (k % 4));
            if (k >= 1) begin
                chk($sformatf("fair m_bvalid %0d", k), m_bvalid, 1);
                chk($sformatf("fair m_bid %0d", k), m_bid, {2'((k - 1) % 4), 4'((k - 1) % 4)});
            end
            step();
        end
        s_bvalid = '0;
        step(); step();

        // Backpressure: seven cycles of M_BREADY low while holding a SLVERR.
        s_bvalid = 4'b0010; s_bid = 16'h0090; s_bresp = 8'h08; m_bready = 1'b0;
        #1;
        chk("bp grant", s_bready, 4'b0010);
        step();
        s_bvalid = 4'b0001; s_bid = 16'h0000; s_bresp = '0;
        stall_pulses = 0;
        for (int j = 0; j <= 7; j++) begin
            chk($sformatf("bp m_bvalid %0d", j), m_bvalid, 1);
            chk($sformatf("bp m_bid %0d", j), m_bid, 6'h19);
            chk($sformatf("bp m_bresp %0d", j), m_bresp, BRESP_SLVERR);
            chk($sformatf("bp s_bready %0d", j), s_bready, 0);
            chk($sformatf("bp stall %0d", j), stall_err, (j == 5) ? 1 : 0);
            if (stall_err) stall_pulses++;
            if (j < 7) step();
        end
        chk("bp stall pulse count", stall_pulses, 1);
        m_bready = 1'b1;
        #1;
        chk("bp release s_bready", s_bready, 4'b0001);
        step();
        s_bvalid = '0;
        #1;
        chk("bp next m_bvalid", m_bvalid, 1);
        chk("bp next m_bid", m_bid, 6'h00);
        chk("bp err_cnt", err_cnt, 1);
        step();
        chk("gap m_bvalid", m_bvalid, 0);
        step();

        chk("protocol violations", proto_viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
